isqrt_arbiter: RTL and testbench
================================

Name: isqrt_arbiter

Overview:
- Shares one pipelined isqrt instance between N_REQ independent requesters, such as several formula FSMs or sqrt clients.
- Arbitrates round-robin and issues at most one isqrt request per cycle.
- Records the requester index of every in-flight request in an in-order tag FIFO.
- Routes each isqrt result back to the requester that issued it.
- Sits between the client FSMs and the single isqrt instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DEPTH, 8, maximum in-flight isqrt requests, which is the tag FIFO depth (power of 2, at least 2).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- req_vld  input  N_REQ  request valid, per requester.
- req_x  input  32*N_REQ  operand; requester i uses bits [32*i+31:32*i].
- req_rdy  output  N_REQ  grant, one-hot or zero; a transfer occurs when req_vld[i] & req_rdy[i].
- rsp_vld  output  N_REQ  result valid, one-hot or zero, one-cycle pulse.
- rsp_y  output  16  result value, shared by all requesters; qualified by rsp_vld.
- isqrt_x_vld  output  1  request to isqrt.
- isqrt_x  output  32  operand to isqrt.
- isqrt_y_vld  input  1  isqrt result valid.
- isqrt_y  input  16  isqrt result.
- err_orphan  output  1  sticky flag: a result arrived with no request in flight.

Behaviour:
- isqrt contract: accepts one request per cycle, has no backpressure, returns results in issue order, and has arbitrary fixed latency of at least 1.
- Arbitration is combinational from req_vld, rr_ptr and count:
  - When count == DEPTH, req_rdy = 0.
  - Otherwise grant goes to the first i with req_vld[i] set, searching from rr_ptr upward and wrapping modulo N_REQ.
  - At most one grant per cycle.
- Full check uses the registered count. A simultaneous pop does not free a slot in the same cycle.
- Issue:
  - isqrt_x_vld = |req_rdy.
  - isqrt_x = req_x of the granted requester; don't-care when no grant.
  - Zero cycles from accept to isqrt request.
- rr_ptr:
  - Reset value 0.
  - On a grant to requester w, rr_ptr <= (w+1) mod N_REQ.
  - Unchanged when there is no grant.
- Tag FIFO:
  - On grant, push w, width clog2(N_REQ).
  - On isqrt_y_vld with count > 0, pop the head tag.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - count ranges 0..DEPTH.
- Response, registered with one cycle latency after isqrt_y_vld:
  - rsp_vld <= onehot(head tag) when isqrt_y_vld & count > 0, else 0.
  - rsp_y <= isqrt_y when isqrt_y_vld; otherwise holds its value.
- Orphan:
  - isqrt_y_vld with count == 0 sets err_orphan.
  - That result is dropped: no rsp_vld, no pop.
  - err_orphan clears only on rst.
- Reset values:
  - req_rdy = 0 and isqrt_x_vld = 0 while rst is high. Grant is gated by rst.
  - rsp_vld = 0, rsp_y = 0, err_orphan = 0.
  - count = 0, rr_ptr = 0, FIFO pointers = 0.
- Reset mid-operation: all in-flight tags are discarded. Results arriving after reset count as orphans. The surrounding system resets isqrt together with this block.
- No starvation: a requester holding req_vld is granted within N_REQ non-full cycles.

Test Plan:
- Single request: req_vld = 0001, req_x[0] = 144, isqrt latency 3.
  - Required: req_rdy = 0001 and isqrt_x = 144 in cycle 0.
  - Required: rsp_vld = 0001 and rsp_y = 12 in cycle 4.
- All four requesters held valid continuously from reset:
  - Required: grants in order 0, 1, 2, 3, 0, 1, ….
  - Required: responses return in the same order with correct roots of x = 0, 1, 15, 0xFFFF_FFFF, giving 0, 1, 3, 65535.
- Full stall: DEPTH = 8, isqrt latency 20, requester 2 streams.
  - Required: exactly 8 grants, then req_rdy = 0 until the first result.
  - Required: then exactly one grant per result.
- Simultaneous push and pop at count = DEPTH−1: count stays DEPTH−1 and the tag ordering is preserved.
- Orphan: pulse isqrt_y_vld with no request outstanding.
  - Required: err_orphan = 1 from the next cycle.
  - Required: no rsp_vld, and the flag stays set until rst.
- Mid-stream reset with 5 in flight:
  - Required: rsp_vld = 0, req_rdy = 0 during rst.
  - Required: afterwards a new request from requester 3 is granted immediately, since rr_ptr = 0 and requester 3 is the only one valid.

Source files
------------

// File: rtl/isqrt_arbiter.sv
// Round-robin front end that shares one pipelined isqrt between N_REQ clients.
// An in-order tag FIFO records which client issued each request and steers each result back to it.
module isqrt_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_vld,
    input  logic [32*N_REQ-1:0]   req_x,
    output logic [N_REQ-1:0]      req_rdy,
    output logic [N_REQ-1:0]      rsp_vld,
    output logic [15:0]           rsp_y,
    output logic                  isqrt_x_vld,
    output logic [31:0]           isqrt_x,
    input  logic                  isqrt_y_vld,
    input  logic [15:0]           isqrt_y,
    output logic                  err_orphan
);

    localparam int unsigned TAG_W = $clog2(N_REQ);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TAG_W-1:0] tag_mem_q [DEPTH];
    logic [TAG_W-1:0] tag_mem_d [DEPTH];
    logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
    logic [15:0]      rsp_y_q, rsp_y_d;
    logic             err_orphan_q, err_orphan_d;

    logic             full_c;
    logic             grant_any_c;
    logic [TAG_W-1:0] grant_idx_c;
    logic [N_REQ-1:0] grant_c;
    logic             push_c;
    logic             pop_c;
    logic             orphan_c;
    logic [TAG_W-1:0] head_tag_c;

    // (a + k) mod N_REQ, valid for a < N_REQ and k <= N_REQ
    function automatic logic [TAG_W-1:0] wrap_add(input logic [TAG_W-1:0] a, input int unsigned k);
        int unsigned s;
        s = 32'(a) + k;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return TAG_W'(s);
    endfunction

    // Round-robin search starting at rr_ptr; gated by reset and the registered full flag
    always_comb begin
        full_c      = (count_q == CNT_W'(DEPTH));
        grant_any_c = 1'b0;
        grant_idx_c = '0;
        if (!rst && !full_c) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (!grant_any_c && req_vld[wrap_add(rr_ptr_q, k)]) begin
                    grant_any_c = 1'b1;
                    grant_idx_c = wrap_add(rr_ptr_q, k);
                end
            end
        end
        grant_c = grant_any_c ? (N_REQ'(1) << grant_idx_c) : '0;
    end

    assign req_rdy     = grant_c;
    assign isqrt_x_vld = grant_any_c;
    assign isqrt_x     = req_x[32*grant_idx_c +: 32];

    assign push_c     = grant_any_c;
    assign pop_c      = isqrt_y_vld && (count_q != '0);
    assign orphan_c   = isqrt_y_vld && (count_q == '0);
    assign head_tag_c = tag_mem_q[rd_ptr_q];

    // Next-state for pointers, tag storage, and the registered response path
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        tag_mem_d    = tag_mem_q;
        rsp_vld_d    = '0;
        rsp_y_d      = rsp_y_q;
        err_orphan_d = err_orphan_q | orphan_c;

        if (grant_any_c) begin
            rr_ptr_d = wrap_add(grant_idx_c, 1);
        end
        if (push_c) begin
            tag_mem_d[wr_ptr_q] = grant_idx_c;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            rsp_vld_d = N_REQ'(1) << head_tag_c;
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (isqrt_y_vld) begin
            rsp_y_d = isqrt_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_vld_q    <= '0;
            rsp_y_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_y_q      <= rsp_y_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // Tag storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        tag_mem_q <= tag_mem_d;
    end

    assign rsp_vld    = rsp_vld_q;
    assign rsp_y      = rsp_y_q;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_isqrt_arbiter.sv
// Directed bench for isqrt_arbiter with a fixed-latency isqrt model behind it.
// Inputs change and outputs are checked just after the falling clock edge.
module tb_isqrt_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_vld = '0;
    logic [127:0] req_x = '0;
    logic [3:0]   req_rdy;
    logic [3:0]   rsp_vld;
    logic [15:0]  rsp_y;
    logic         isqrt_x_vld;
    logic [31:0]  isqrt_x;
    logic         isqrt_y_vld;
    logic [15:0]  isqrt_y;
    logic         err_orphan;

    logic         inj = 1'b0;
    int           lat = 3;
    logic         pipe_vld [32];
    logic [31:0]  pipe_x   [32];

    int n_checks = 0;
    int n_errors = 0;

    isqrt_arbiter #(.N_REQ(4), .DEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_x       (req_x),
        .req_rdy     (req_rdy),
        .rsp_vld     (rsp_vld),
        .rsp_y       (rsp_y),
        .isqrt_x_vld (isqrt_x_vld),
        .isqrt_x     (isqrt_x),
        .isqrt_y_vld (isqrt_y_vld),
        .isqrt_y     (isqrt_y),
        .err_orphan  (err_orphan)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_isqrt(input logic [31:0] x);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'(1) << b);
            if (32'(t) * 32'(t) <= x) r = t;
        end
        return r;
    endfunction

    // isqrt stand-in: fixed latency lat, reset together with the arbiter
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) pipe_vld[i] <= 1'b0;
        end else begin
            pipe_vld[0] <= isqrt_x_vld;
            pipe_x[0]   <= isqrt_x;
            for (int i = 1; i < 32; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_x[i]   <= pipe_x[i-1];
            end
        end
    end

    assign isqrt_y_vld = inj | pipe_vld[lat-1];
    assign isqrt_y     = inj ? 16'h0007 : model_isqrt(pipe_x[lat-1]);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_vld = '0;
        inj = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [15:0] exp_y [4];
    logic [3:0]  exp_rdy;

    initial begin
        // ---- reset values and single request, latency 3
        lat = 3;
        do_reset();
        check("reset_rsp_vld", 64'(rsp_vld), 64'h0);
        check("reset_rsp_y", 64'(rsp_y), 64'h0);
        check("reset_err_orphan", 64'(err_orphan), 64'h0);

        @(negedge clk);
        req_x[31:0] = 32'd144;
        req_vld = 4'b0001;
        #1;
        check("single_rdy", 64'(req_rdy), 64'h1);
        check("single_x_vld", 64'(isqrt_x_vld), 64'h1);
        check("single_x", 64'(isqrt_x), 64'd144);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            req_vld = '0;
            #1;
            check("single_rsp_early", 64'(rsp_vld), 64'h0);
        end
        @(negedge clk);
        #1;
        check("single_rsp_vld", 64'(rsp_vld), 64'h1);
        check("single_rsp_y", 64'(rsp_y), 64'd12);
        @(negedge clk);
        #1;
        check("single_rsp_pulse", 64'(rsp_vld), 64'h0);
        check("single_rsp_hold", 64'(rsp_y), 64'd12);

        // ---- all four requesters valid from reset
        rst = 1'b1;
        req_vld = 4'hF;
        req_x = {32'hFFFF_FFFF, 32'd15, 32'd1, 32'd0};
        exp_y[0] = 16'd0;
        exp_y[1] = 16'd1;
        exp_y[2] = 16'd3;
        exp_y[3] = 16'd65535;
        repeat (2) @(negedge clk);
        #1;
        check("rst_gate_rdy", 64'(req_rdy), 64'h0);
        check("rst_gate_x_vld", 64'(isqrt_x_vld), 64'h0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rst = 1'b0;
            req_vld = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) check("rr_grant", 64'(req_rdy), 64'(4'(1) << (c % 4)));
            if (c >= 4) begin
                check("rr_rsp_vld", 64'(rsp_vld), 64'(4'(1) << ((c - 4) % 4)));
                check("rr_rsp_y", 64'(rsp_y), 64'(exp_y[(c - 4) % 4]));
            end
        end

        // ---- full stall: latency 20, requester 2 streams x = c*c
        lat = 20;
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            req_vld = 4'b0100;
            req_x[95:64] = 32'(c * c);
            #1;
            exp_rdy = ((c <= 7) || (c >= 21 && c <= 28)) ? 4'b0100 : 4'b0000;
            check("full_rdy", 64'(req_rdy), 64'(exp_rdy));
            if (c >= 21 && c <= 28) begin
                check("full_rsp_vld", 64'(rsp_vld), 64'h4);
                check("full_rsp_y", 64'(rsp_y), 64'(c - 21));
            end
        end

        // ---- orphan result
        do_reset();
        @(negedge clk);
        inj = 1'b1;
        #1;
        check("orphan_before", 64'(err_orphan), 64'h0);
        @(negedge clk);
        inj = 1'b0;
        #1;
        check("orphan_set", 64'(err_orphan), 64'h1);
        check("orphan_no_rsp", 64'(rsp_vld), 64'h0);
        check("orphan_rsp_y", 64'(rsp_y), 64'h7);
        repeat (3) @(negedge clk);
        #1;
        check("orphan_sticky", 64'(err_orphan), 64'h1);
        check("orphan_no_rsp_late", 64'(rsp_vld), 64'h0);
        do_reset();
        check("orphan_cleared", 64'(err_orphan), 64'h0);

        // ---- mid-stream reset with 5 in flight
        lat = 20;
        do_reset();
        req_x[31:0] = 32'd400;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_vld = 4'b0001;
            #1;
            check("mid_grant", 64'(req_rdy), 64'h1);
        end
        @(negedge clk);
        rst = 1'b1;
        req_vld = 4'hF;
        #1;
        check("mid_rst_rdy", 64'(req_rdy), 64'h0);
        check("mid_rst_x_vld", 64'(isqrt_x_vld), 64'h0);
        @(negedge clk);
        #1;
        check("mid_rst_rsp_vld", 64'(rsp_vld), 64'h0);
        check("mid_rst_rdy2", 64'(req_rdy), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        req_vld = 4'b1000;
        req_x[127:96] = 32'd49;
        #1;
        check("post_rst_grant", 64'(req_rdy), 64'h8);
        check("post_rst_x", 64'(isqrt_x), 64'd49);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            req_vld = '0;
        end
        @(negedge clk);
        #1;
        check("post_rst_rsp_vld", 64'(rsp_vld), 64'h8);
        check("post_rst_rsp_y", 64'(rsp_y), 64'd7);
        check("post_rst_no_orphan", 64'(err_orphan), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
